// File: rtl/int_div.sv
`default_nettype none
// int_div: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Constant latency: o_valid is high WIDTH+2 cycles after the accept cycle.
module int_div #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_signed,
  input  logic             i_rem,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);
  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_q, result_q;
  logic             neg_q_q, neg_r_q, sel_rem_q, div0_q, ovf_q, valid_q;

  logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0]   trial;

  assign abs_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign abs_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  // One extra bit: the shifted partial remainder can reach 2*divisor-1.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  assign quo_fix = div0_q ? {WIDTH{1'b1}} :
                   ovf_q  ? a_q :
                   neg_q_q ? -quo_q : quo_q;
  assign rem_fix = div0_q ? a_q :
                   ovf_q  ? {WIDTH{1'b0}} :
                   neg_r_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      result_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (i_valid) begin
          quo_q     <= abs_a;
          dvs_q     <= abs_b;
          a_q       <= i_a;
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_q_q   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]) & (i_b != '0);
          neg_r_q   <= i_signed & i_a[WIDTH-1];
          sel_rem_q <= i_rem;
          div0_q    <= (i_b == '0);
          ovf_q     <= i_signed & (i_a == MIN_NEG) & (i_b == {WIDTH{1'b1}});
        end
        CALC: begin
          if (!trial[WIDTH]) rem_q <= trial[WIDTH-1:0];
          else               rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          result_q <= sel_rem_q ? rem_fix : quo_fix;
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_q == CALC) || (state_q == FIX);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_int_div.sv
`default_nettype none
// tb_int_div: directed vectors for int_div, checked by a scoreboard monitor.
module tb_int_div;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0, rst_n = 1'b0, vld = 1'b0, sgn = 1'b0, rm = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, ovld;
  logic [W-1:0] res;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] exp;
    int           due;
    string        name;
  } exp_t;
  exp_t sb[$];

  int_div #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_signed(sgn), .i_rem(rm),
    .i_a(a), .i_b(b), .o_busy(busy), .o_valid(ovld), .o_result(res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ovld) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stray_valid: got o_valid=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, res, e.exp);
        check({e.name, "_latency"}, W'(cyc), W'(e.due));
      end
    end
  end

  // Called at a negedge; presents the operands for one cycle then scrambles them.
  task automatic issue(input bit s, input bit r, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp, input string name, input bit track = 1'b1);
    exp_t e;
    sgn = s; rm = r; a = x; b = y; vld = 1'b1;
    if (track) begin
      e.exp = exp; e.due = cyc + LAT; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    vld = 1'b0;
    a = $urandom; b = $urandom; sgn = 1'($urandom); rm = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input bit s, input bit r, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp, input string name);
    issue(s, r, x, y, exp, name);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_valid", W'(ovld), '0);
    check("reset_result", res, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, "remu_100_7");
    run(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_m7_2");
    run(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_m7_2");
    run(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, "rem_7_m2");
    run(1'b1, 1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, "div_m100_m7");
    run(1'b1, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, "rem_m100_m7");
    run(1'b0, 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, "divu_by0");
    run(1'b1, 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, "div_by0");
    run(1'b0, 1'b1, 32'h12345678, 32'd0, 32'h12345678, "remu_by0");
    run(1'b1, 1'b1, 32'h12345678, 32'd0, 32'h12345678, "rem_by0");
    run(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
    run(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, "divu_big");
    run(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "remu_big");
    run(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, "divu_wide");
    run(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, "remu_wide");

    // i_valid pulses while busy must be ignored
    issue(1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, "divu_ignore");
    for (int k = 1; k < LAT; k++) begin
      check($sformatf("busy_k%0d", k), W'(busy), W'(1));
      if (k == 5 || k == 20) begin
        vld = 1'b1; sgn = 1'b0; rm = 1'b0; a = 32'hFFFF; b = 32'd1;
      end else begin
        vld = 1'b0;
      end
      @(negedge clk);
    end
    vld = 1'b0;
    drain("divu_ignore");

    // back-to-back: new request in the o_valid cycle
    issue(1'b0, 1'b0, 32'd50, 32'd5, 32'd10, "divu_b2b_first");
    begin
      int t = 0;
      while (!ovld && t < 60) begin
        @(negedge clk);
        t++;
      end
      check("b2b_valid_seen", W'(ovld), W'(1));
    end
    issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, "divu_b2b_second");
    drain("divu_b2b");

    // reset mid-operation aborts it
    issue(1'b0, 1'b0, 32'd77, 32'd7, 32'd11, "abort", 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_valid", W'(ovld), '0);
    check("abort_result", res, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(1'b0, 1'b0, 32'd9, 32'd3, 32'd3, "divu_9_3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
